// File: rtl/imem_loader.sv
// imem_loader -- boot-time writer for the core's instruction memory.
//
// Receives a byte stream over a valid/ready handshake. The stream is a 32-bit
// little-endian word count N followed by N little-endian instruction words.
// Each word is written to the instruction memory at sequential word addresses.
// The processor core is held in reset until the whole image is loaded.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): a trailing little-endian
// 32-bit checksum must equal the modulo-2^32 sum of the data words, otherwise
// the load ends in ERROR.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   start        begin a load (honoured in IDLE, DONE or ERROR only)
//   in_valid     in_data holds a valid byte
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (LEN, DATA, CHECK)
//   imem_we      one-cycle instruction memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   instruction word to write
//   core_rst     reset to the processor core, low only in DONE
//   busy         load in progress
//   done         image loaded, core released
//   error        load aborted
//   words_loaded words written in the current load

module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // Memory capacity in words; N may equal it but not exceed it.
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

    // State reached once all data words are in (or N == 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;    // first three bytes of the current 32-bit field
    logic [31:0] length;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    logic                accept;
    logic                last_byte;
    logic [31:0]         full_word;
    logic [ADDR_WIDTH:0] words_next;

    assign accept     = in_valid && in_ready;
    assign last_byte  = (byte_cnt == 2'd3);
    // The byte arriving now is the most significant one of the field.
    assign full_word  = {in_data, byte_buf};
    assign words_next = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        // NOTE: nxt is a scratch variable local to this block, so it is
        // assigned with '=' and read back in the same cycle; every real
        // register below uses '<='.
        state_t nxt;
        nxt = state;

        // NOTE: default low every cycle makes imem_we a single-cycle pulse.
        imem_we <= 1'b0;

        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            byte_buf     <= '0;
            length       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            if (accept) begin
                byte_buf <= {in_data, byte_buf[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        nxt = S_LEN;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
                        length       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum          <= '0;
`endif
                    end
                end

                S_LEN: begin
                    if (accept && last_byte) begin
                        length <= full_word;
                        if ({1'b0, full_word} > CAPACITY) begin
                            nxt = S_ERROR;
                        end else if (full_word == 32'd0) begin
                            nxt = S_FINISH;
                        end else begin
                            nxt = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept && last_byte) begin
                        imem_we      <= 1'b1;
                        imem_wdata   <= full_word;
                        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                        words_loaded <= words_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum          <= sum + full_word;
`endif
                        // length never exceeds CAPACITY here, so the
                        // zero-extended count compares exactly.
                        if ({{(31 - ADDR_WIDTH){1'b0}}, words_next} == length) begin
                            nxt = S_FINISH;
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept && last_byte) begin
                        nxt = (full_word == sum) ? S_DONE : S_ERROR;
                    end
                end
`endif

                default: nxt = S_IDLE;
            endcase

            // Flags are registered from the next state so they change on the
            // same edge as the state itself.
            state    <= nxt;
            busy     <= (nxt == S_LEN) || (nxt == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (nxt == S_CHECK)
`endif
                        ;
            in_ready <= (nxt == S_LEN) || (nxt == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (nxt == S_CHECK)
`endif
                        ;
            done     <= (nxt == S_DONE);
            error    <= (nxt == S_ERROR);
            core_rst <= (nxt != S_DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for imem_loader (default ADDR_WIDTH = 8).
// Table-driven image loads with random data words and random byte gaps,
// compared against a simple image model, plus hand-written corner sequences.

module tb_imem_loader;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write log captured mid-cycle, away from the active edge.
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        done_at;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        if (imem_we) wlog.push_back('{int'(imem_addr), imem_wdata, done});
    end

    // Image under test: bytes to send and the data words they encode.
    logic [7:0]  stream[$];
    logic [31:0] dwords[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_le(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
    endtask

    // Builds header + random data words (+ checksum when enabled).
    task automatic build_image(input logic [31:0] header, input int n_data);
        logic [31:0] s;
        stream.delete();
        dwords.delete();
        s = 32'd0;
        push_le(header);
        for (int i = 0; i < n_data; i++) begin
            dwords.push_back($urandom);
            push_le(dwords[i]);
            s += dwords[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if ({1'b0, header} <= 33'(CAP)) push_le(s);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int waited;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        start    = poke;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_load();
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_in_ready", 64'(in_ready), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check("start_error", 64'(error), 64'd0);
        check("start_core_rst", 64'(core_rst), 64'd1);
        check("start_words", 64'(words_loaded), 64'd0);
    endtask

    task automatic send_stream(input int max_gap, input bit poke);
        for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)), poke);
    endtask

    // Compares final flags and the write log against the image model.
    task automatic verify(input string tag, input bit exp_done, input bit exp_err, input int exp_n);
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_done));
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'(exp_n));
        tick();
        check({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_n));
        for (int i = 0; i < wlog.size() && i < exp_n; i++) begin
            check({tag, "_addr"}, 64'(wlog[i].addr), 64'(i));
            check({tag, "_data"}, 64'(wlog[i].data), 64'(dwords[i]));
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_done && exp_n > 0 && wlog.size() > 0)
            check({tag, "_done_with_last_we"}, 64'(wlog[wlog.size()-1].done_at), 64'd1);
`endif
    endtask

    typedef struct {
        logic [31:0] header;
        int          n_data;
        int          max_gap;
        bit          poke_start;
        bit          exp_done;
        bit          exp_error;
        int          exp_words;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{32'd2,          2,   0, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{32'd0,          0,   0, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{32'd257,        0,   0, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{32'd2,          2,   5, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{32'd7,          7,   3, 1'b1, 1'b1, 1'b0, 7});
        vecs.push_back('{32'hFFFF_FFFF,  0,   2, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{32'd256,        256, 0, 1'b0, 1'b1, 1'b0, 256});
        vecs.push_back('{32'd1,          1,   5, 1'b0, 1'b1, 1'b0, 1});

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);

        // Fixed two-word image with literal bytes and literal expected words.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00};
        dwords = '{32'h0050_0093, 32'h00A0_0113};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'hA6); stream.push_back(8'h01);
        stream.push_back(8'hF0); stream.push_back(8'h00);
`endif
        start_load();
        send_stream(0, 1'b0);
        verify("fixed2", 1'b1, 1'b0, 2);

        // Bytes offered while DONE must be refused.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_refuse_ready", 64'(in_ready), 64'd0);
            check("done_hold", 64'(done), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("done_no_write", 64'(wlog.size()), 64'd2);
        check("done_words_hold", 64'(words_loaded), 64'd2);

        // Table of randomized loads.
        foreach (vecs[v]) begin
            build_image(vecs[v].header, vecs[v].n_data);
            start_load();
            send_stream(vecs[v].max_gap, vecs[v].poke_start);
            verify($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_error,
                   vecs[v].exp_words);
        end

        // Reset after six data bytes of a two-word load.
        build_image(32'd2, 2);
        start_load();
        for (int i = 0; i < 10; i++) send_byte(stream[i], 0, 1'b0);
        check("midload_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_we", 64'(imem_we), 64'd0);
        check("midrst_addr", 64'(imem_addr), 64'd0);
        check("midrst_wdata", 64'(imem_wdata), 64'd0);
        check("midrst_core_rst", 64'(core_rst), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_words", 64'(words_loaded), 64'd0);
        tick();
        check("midrst_idle_ready", 64'(in_ready), 64'd0);
        start_load();
        send_stream(2, 1'b0);
        verify("after_rst", 1'b1, 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: words stay written, core stays in reset.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dwords = '{32'h0050_0093, 32'h00A0_0113};
        start_load();
        send_stream(1, 1'b0);
        verify("bad_checksum", 1'b0, 1'b1, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
